// File: rtl/twiddle_fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | twiddle_fetch_if : {real, imag} twiddle stream with stage/bfly tags  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
interface twiddle_fetch_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 3
) ();
  logic [DATA_WIDTH-1:0] tw_r;
  logic [DATA_WIDTH-1:0] tw_i;
  logic [3:0]            tw_stage;
  logic [ADDR_WIDTH-1:0] tw_bfly;
  logic                  tw_last;
  logic                  tw_valid;
  logic                  tw_ready;

  modport master (
    output tw_r, tw_i, tw_stage, tw_bfly, tw_last, tw_valid,
    input  tw_ready
  );

  modport slave (
    input  tw_r, tw_i, tw_stage, tw_bfly, tw_last, tw_valid,
    output tw_ready
  );
endinterface
`default_nettype wire

// File: rtl/twiddle_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | twiddle_fetch : radix-2 DIT twiddle ROM sequencer with 2-deep skid   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module twiddle_fetch #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_r_q,
  input  logic [DATA_WIDTH-1:0] rom_i_q,
  twiddle_fetch_if.master       tw
);

  localparam logic [3:0]            LAST_STAGE = 4'(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_BFLY  = '1;
  localparam logic [ADDR_WIDTH-1:0] BFLY_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
    logic [3:0]            stage;
    logic [ADDR_WIDTH-1:0] bfly;
    logic                  last;
  } pair_t;

  state_t                state_q, state_d;
  logic [3:0]            s_q, s_d;
  logic [ADDR_WIDTH-1:0] j_q, j_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [3:0]            rd_stage_q, rd_stage_d;
  logic [ADDR_WIDTH-1:0] rd_bfly_q, rd_bfly_d;
  logic                  rd_last_q, rd_last_d;
  pair_t                 head_q, head_d;
  pair_t                 tail_q, tail_d;
  logic [1:0]            cnt_q, cnt_d;

  logic                  pop;
  logic                  issue_last;
  logic [2:0]            occ;
  logic [1:0]            cnt_left;
  logic [ADDR_WIDTH-1:0] mask;
  logic [3:0]            shamt;
  logic [ADDR_WIDTH-1:0] k;
  pair_t                 incoming;

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    j_d        = j_q;
    addr_d     = addr_q;
    rd_valid_d = 1'b0;
    rd_stage_d = rd_stage_q;
    rd_bfly_d  = rd_bfly_q;
    rd_last_d  = rd_last_q;
    head_d     = head_q;
    tail_d     = tail_q;
    done       = 1'b0;

    pop        = (cnt_q != 2'd0) && tw.tw_ready;
    // Space check counts the pair leaving this cycle and the read returning now.
    occ        = {1'b0, cnt_q} + {2'b00, rd_valid_q} - {2'b00, pop};
    issue_last = (s_q == LAST_STAGE) && (j_q == LAST_BFLY);
    mask       = ~(LAST_BFLY << s_q);
    shamt      = LAST_STAGE - s_q;
    k          = (j_q & mask) << shamt;
    incoming   = {rom_r_q, rom_i_q, rd_stage_q, rd_bfly_q, rd_last_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          s_d     = 4'd0;
          j_d     = '0;
        end
      end
      S_RUN: begin
        if (occ < 3'd2) begin
          addr_d     = k;
          rd_valid_d = 1'b1;
          rd_stage_d = s_q;
          rd_bfly_d  = j_q;
          rd_last_d  = issue_last;
          if (issue_last) begin
            state_d = S_DRAIN;
          end else if (j_q == LAST_BFLY) begin
            j_d = '0;
            s_d = s_q + 4'd1;
          end else begin
            j_d = j_q + BFLY_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (pop && head_q.last) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Skid buffer: shift on pop, then land returning ROM data behind survivors.
    cnt_left = cnt_q - {1'b0, pop};
    if (pop && (cnt_q == 2'd2)) begin
      head_d = tail_q;
    end
    if (rd_valid_q) begin
      if (cnt_left == 2'd0) begin
        head_d = incoming;
      end else begin
        tail_d = incoming;
      end
    end
    cnt_d = cnt_left + {1'b0, rd_valid_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      s_q        <= 4'd0;
      j_q        <= '0;
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_stage_q <= 4'd0;
      rd_bfly_q  <= '0;
      rd_last_q  <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      j_q        <= j_d;
      addr_q     <= addr_d;
      rd_valid_q <= rd_valid_d;
      rd_stage_q <= rd_stage_d;
      rd_bfly_q  <= rd_bfly_d;
      rd_last_q  <= rd_last_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign rom_addr    = addr_d;
  assign tw.tw_valid = (cnt_q != 2'd0);
  assign tw.tw_r     = head_q.re;
  assign tw.tw_i     = head_q.im;
  assign tw.tw_stage = head_q.stage;
  assign tw.tw_bfly  = head_q.bfly;
  assign tw.tw_last  = head_q.last;

endmodule
`default_nettype wire

// File: doc/twiddle_fetch.md
Name: twiddle_fetch

Overview:
- Read-side sequencer for the two FFT twiddle ROMs: the real-part ROM and the imaginary-part ROM. Both have a registered output and one-cycle read latency.
- Generates radix-2 DIT twiddle addresses stage by stage and drives one shared address bus to both ROMs.
- Absorbs the ROM latency and delivers {real, imag} twiddle pairs to the butterfly datapath over a valid/ready stream with full backpressure.
- Sits between the ROM pair and the FFT butterfly controller; one start pulse streams the twiddles for one complete FFT.

Parameters:
- DATA_WIDTH, 18, twiddle word width; must match the ROM DATA_WIDTH.
- ADDR_WIDTH, 3, ROM address width. ROM depth is 2^ADDR_WIDTH, the FFT size is N = 2^(ADDR_WIDTH+1), and the stage count is ADDR_WIDTH+1. Legal range 1..14.

Ports:
- clk, in, 1, system clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse that begins one FFT's twiddle sequence; honoured only when busy=0.
- busy, out, 1, high from the cycle after an accepted start until the cycle done pulses.
- done, out, 1, one-cycle pulse on the cycle the last pair is accepted downstream.
- rom_addr, out, ADDR_WIDTH, shared address to both ROMs.
- rom_r_q, in, DATA_WIDTH, real ROM output, equal to rom_r[rom_addr of the previous cycle].
- rom_i_q, in, DATA_WIDTH, imaginary ROM output, same timing as rom_r_q.
- tw_r, out, DATA_WIDTH, real twiddle, held stable while tw_valid=1 and tw_ready=0.
- tw_i, out, DATA_WIDTH, imaginary twiddle, same hold rule as tw_r.
- tw_stage, out, 4, FFT stage s of the current pair.
- tw_bfly, out, ADDR_WIDTH, butterfly index j within the stage.
- tw_last, out, 1, marks the final pair of the sequence.
- tw_valid, out, 1, output pair valid.
- tw_ready, in, 1, downstream accept.

Behaviour:
- Reset: rst_n low asynchronously clears all registers. Outputs during and after reset: busy=0, done=0, rom_addr=0, tw_r=0, tw_i=0, tw_stage=0, tw_bfly=0, tw_last=0, tw_valid=0.
- Reset mid-sequence aborts the sequence; no partial pairs appear after reset release.
- Sequence order:
  - s runs 0..ADDR_WIDTH (outer loop); j runs 0..2^ADDR_WIDTH-1 (inner loop).
  - Address k = (j mod 2^s) << (ADDR_WIDTH-s), computed in ADDR_WIDTH bits.
  - Total pairs P = (ADDR_WIDTH+1)*2^ADDR_WIDTH; P = 32 at the defaults.
- FSM:
  - IDLE -> RUN on start. The issue counters (s, j) load 0 and busy rises on the next edge.
  - RUN issues one address per cycle while buffer space allows.
  - RUN -> DRAIN after the last address issues. DRAIN waits until all issued pairs are accepted.
  - DRAIN -> IDLE on acceptance of the tw_last pair. done pulses in that same cycle and busy falls on the next edge.
- Start handling:
  - start is ignored in RUN and DRAIN.
  - start in the same cycle as the final acceptance is ignored.
- Latency:
  - First rom_addr is presented in the cycle after start is sampled.
  - First tw_valid rises 2 cycles after that address is presented.
  - Sustained throughput is 1 pair/cycle while tw_ready=1.
- Buffering:
  - ROM data is captured the cycle after its address issues, into a 2-entry skid buffer. The buffer head drives the tw_* outputs.
  - An address issues only when (buffered pairs + in-flight reads) < 2, counting the acceptance happening in the same cycle.
  - No pair is dropped, duplicated or reordered under any tw_ready pattern.
  - tw_stage, tw_bfly and tw_last travel with their data.
  - rom_addr holds its last value when not issuing.
- Handshake:
  - A transfer occurs on tw_valid && tw_ready.
  - tw_valid never falls without a transfer, except on reset.
  - tw_valid does not depend combinationally on tw_ready.
- Wrap:
  - j wraps at 2^ADDR_WIDTH-1 and s increments.
  - The pair with s=ADDR_WIDTH and j=2^ADDR_WIDTH-1 carries tw_last=1.

Test Plan:
- Reset, then start with tw_ready=1 and the default parameters:
  - 32 pairs on consecutive cycles; first tw_valid 3 cycles after start.
  - Stage 0: all 8 pairs are rom[0].
  - Stage 3: pairs are rom[0..7] in order.
  - done coincides with the 32nd transfer, which has tw_last=1.
- Stage 1 and stage 2 address check:
  - Stage 1 rom_addr sequence is 0,4,0,4,0,4,0,4.
  - Stage 2 rom_addr sequence is 0,2,4,6,0,2,4,6.
  - tw_r and tw_i match the ROM init files for those addresses.
- Random backpressure (tw_ready at 30% duty, seeded): the received stream is identical to the tw_ready=1 run; tw_* stay stable during every stall.
- tw_ready held low for 20 cycles from start:
  - At most 2 reads are issued and tw_valid holds pair 0.
  - Releasing tw_ready resumes with no loss of pairs.
- start pulsed again mid-sequence and on the done cycle: both ignored; exactly 32 pairs result; busy stays high until done.
- rst_n asserted at pair 17 and released, then a new start: outputs zero during reset; a fresh 32-pair sequence from s=0, j=0 follows.
